// File: rtl/multicycle_mips_if.sv
// Memory-side bus of multicycle_mips: instruction fetch port, data-memory port
// (active-low CEN/OEN/WEN) and the retire pulse.
interface multicycle_mips_if #(
  parameter int unsigned DMEM_AW = 7
);
  logic [31:0]        IR_addr;
  logic [31:0]        IR;
  logic               IR_ready;
  logic [31:0]        ReadDataMem;
  logic               DMEM_ready;
  logic               CEN;
  logic               OEN;
  logic               WEN;
  logic [DMEM_AW-1:0] A;
  logic [31:0]        Data2Mem;
  logic               retire;

  // Core side.
  modport master (
    output IR_addr, CEN, OEN, WEN, A, Data2Mem, retire,
    input  IR, IR_ready, ReadDataMem, DMEM_ready
  );

  // Memory / environment side.
  modport slave (
    input  IR_addr, CEN, OEN, WEN, A, Data2Mem, retire,
    output IR, IR_ready, ReadDataMem, DMEM_ready
  );
endinterface

// File: rtl/multicycle_mips.sv
// multicycle_mips: multi-cycle MIPS subset core, FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Stalls on IR_ready and DMEM_ready. Define MULT_EN to add HI/LO with mult/mfhi/mflo.
module multicycle_mips #(
  parameter int unsigned DMEM_AW   = 7,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned NREG_LOG2 = 5
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_mips_if.master bus
);
  localparam int unsigned NReg = 2 ** NREG_LOG2;

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMem, StWriteback} state_e;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [31:0]          rf_q [NReg];
  logic [31:0]          alu_res, pc4, npc, wb_data;
  logic [NREG_LOG2-1:0] rs, rt, rd, wr_idx;
  logic [5:0]           opcode, funct;
  logic [4:0]           shamt;
  logic is_r, r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic is_mult, is_mfhi, is_mflo, to_wb;

  assign opcode  = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign shamt   = ir_q[10:6];
  assign rs      = ir_q[21 +: NREG_LOG2];
  assign rt      = ir_q[16 +: NREG_LOG2];
  assign rd      = ir_q[11 +: NREG_LOG2];

  assign is_r    = (opcode == 6'h00);
  assign r_alu   = is_r && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02});
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_addi = (opcode == 6'h08);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2b);
  assign is_beq  = (opcode == 6'h04);
  assign is_bne  = (opcode == 6'h05);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);

`ifdef MULT_EN
  logic [31:0] hi_q, lo_q;
  logic [63:0] mul_q;
  assign is_mult = is_r && (funct == 6'h18);
  assign is_mfhi = is_r && (funct == 6'h10);
  assign is_mflo = is_r && (funct == 6'h12);
`else
  assign is_mult = 1'b0;
  assign is_mfhi = 1'b0;
  assign is_mflo = 1'b0;
`endif

  // Anything not going to MEM or WRITEBACK (branches, jumps, unknowns) retires in EXECUTE.
  assign to_wb  = r_alu | is_addi | is_mult | is_mfhi | is_mflo;
  assign wr_idx = is_mult ? '0 : (is_r ? rd : rt);
  assign pc4    = pc_q + 32'd4;

  assign bus.IR_addr = pc_q;

  // ALU: effective address for lw/sw, immediate add, R-type operations.
  always_comb begin
    alu_res = '0;
    if (is_addi || is_lw || is_sw) begin
      alu_res = a_q + imm_q;
    end else if (is_r) begin
      case (funct)
        6'h20:   alu_res = a_q + b_q;
        6'h22:   alu_res = a_q - b_q;
        6'h24:   alu_res = a_q & b_q;
        6'h25:   alu_res = a_q | b_q;
        6'h2a:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
        6'h00:   alu_res = b_q << shamt;
        6'h02:   alu_res = b_q >> shamt;
        default: alu_res = '0;
      endcase
    end
  end

  // PC chosen at the end of EXECUTE for control-flow and unknown instructions.
  always_comb begin
    npc = pc4;
    if (is_beq && (a_q == b_q)) npc = pc4 + {imm_q[29:0], 2'b00};
    if (is_bne && (a_q != b_q)) npc = pc4 + {imm_q[29:0], 2'b00};
    if (is_j || is_jal)         npc = {pc4[31:28], ir_q[25:0], 2'b00};
    if (is_jr)                  npc = a_q;
  end

  // Register-file write data in WRITEBACK.
  always_comb begin
    wb_data = alu_q;
    if (is_lw) wb_data = mdr_q;
`ifdef MULT_EN
    if (is_mfhi) wb_data = hi_q;
    if (is_mflo) wb_data = lo_q;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // FSM next state and bus outputs; strobes are idle outside MEM.
  always_comb begin
    state_d      = state_q;
    bus.CEN      = 1'b1;
    bus.OEN      = 1'b1;
    bus.WEN      = 1'b1;
    bus.A        = '0;
    bus.Data2Mem = '0;
    bus.retire   = 1'b0;
    unique case (state_q)
      StFetch:  if (bus.IR_ready) state_d = StDecode;
      StDecode: state_d = StExecute;
      StExecute: begin
        if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (to_wb) begin
          state_d = StWriteback;
        end else begin
          state_d    = StFetch;
          bus.retire = 1'b1;
        end
      end
      StMem: begin
        bus.CEN = 1'b0;
        bus.A   = alu_q[DMEM_AW+1:2];
        if (is_lw) begin
          bus.OEN = 1'b0;
        end else begin
          bus.WEN      = 1'b0;
          bus.Data2Mem = b_q;
        end
        if (bus.DMEM_ready) begin
          if (is_lw) begin
            state_d = StWriteback;
          end else begin
            state_d    = StFetch;
            bus.retire = 1'b1;
          end
        end
      end
      StWriteback: begin
        state_d    = StFetch;
        bus.retire = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Datapath registers, PC and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int unsigned i = 0; i < NReg; i++) rf_q[i] <= '0;
`ifdef MULT_EN
      hi_q  <= '0;
      lo_q  <= '0;
      mul_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StFetch: if (bus.IR_ready) ir_q <= bus.IR;
        StDecode: begin
          a_q   <= rf_q[rs];
          b_q   <= rf_q[rt];
          imm_q <= {{16{ir_q[15]}}, ir_q[15:0]};
        end
        StExecute: begin
          alu_q <= alu_res;
`ifdef MULT_EN
          mul_q <= $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
`endif
          if (!(is_lw || is_sw || to_wb)) pc_q <= npc;
          if (is_jal) rf_q[{NREG_LOG2{1'b1}}] <= pc4;
        end
        StMem: begin
          if (bus.DMEM_ready) begin
            if (is_lw) mdr_q <= bus.ReadDataMem;
            else       pc_q  <= pc4;
          end
        end
        StWriteback: begin
          pc_q <= pc4;
          if (wr_idx != '0) rf_q[wr_idx] <= wb_data;
`ifdef MULT_EN
          if (is_mult) {hi_q, lo_q} <= mul_q;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_mips.sv
// Self-checking bench for multicycle_mips: directed vector table, a reset-abort
// sequence and random instructions checked against an ISA-level model.
module tb_multicycle_mips;
  localparam int unsigned DmemAw  = 7;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int          NVec    = 19;
  localparam int          NRand   = 300;
`ifdef MULT_EN
  localparam bit MultEn = 1'b1;
`else
  localparam bit MultEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  multicycle_mips_if #(.DMEM_AW(DmemAw)) bus ();

  multicycle_mips #(
    .DMEM_AW  (DmemAw),
    .RESET_PC (ResetPc),
    .NREG_LOG2(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state and the SRAM seen by the DUT.
  logic [31:0] mreg  [32];
  logic [31:0] mdmem [128];
  logic [31:0] dmem  [128];
  logic [31:0] mpc, mhi, mlo;

  typedef struct {
    logic [31:0] ins;
    int          irw;
    int          dmw;
    int          exp_lat;
    logic [31:0] exp_pc;
    int          exp_r;
    logic [31:0] exp_v;
  } vec_t;

  vec_t vecs [NVec];

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_regs(input string name);
    int nbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.rf_q[i] !== mreg[i]) begin
        nbad++;
        $display("  r%0d: dut 0x%08h model 0x%08h", i, dut.rf_q[i], mreg[i]);
      end
    end
    check(name, nbad, 0);
  endtask

  task automatic model_reset();
    mpc = ResetPc;
    mhi = '0;
    mlo = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
  endtask

  task automatic mwrite(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) mreg[idx] = v;
  endtask

  // ISA semantics of one instruction; returns zero-wait latency and memory expectations.
  task automatic model_exec(input logic [31:0] ins, output int lat, output bit mrd,
                            output bit mwr, output logic [6:0] maddr, output logic [31:0] mwd);
    logic [5:0]  op  = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [4:0]  rs  = ins[25:21];
    logic [4:0]  rt  = ins[20:16];
    logic [4:0]  rd  = ins[15:11];
    logic [4:0]  sh  = ins[10:6];
    logic [31:0] s   = mreg[rs];
    logic [31:0] t   = mreg[rt];
    logic [31:0] imm = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] pc4 = mpc + 32'd4;
    logic [31:0] npc = pc4;
    logic [31:0] ea  = s + imm;
    longint      prod;
    lat = 3; mrd = 1'b0; mwr = 1'b0; maddr = ea[8:2]; mwd = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin mwrite(rd, s + t); lat = 4; end
          6'h22: begin mwrite(rd, s - t); lat = 4; end
          6'h24: begin mwrite(rd, s & t); lat = 4; end
          6'h25: begin mwrite(rd, s | t); lat = 4; end
          6'h2a: begin mwrite(rd, ($signed(s) < $signed(t)) ? 32'd1 : 32'd0); lat = 4; end
          6'h00: begin mwrite(rd, t << sh); lat = 4; end
          6'h02: begin mwrite(rd, t >> sh); lat = 4; end
          6'h08: npc = s;
          6'h18: if (MultEn) begin
            prod = longint'($signed(s)) * longint'($signed(t));
            mhi  = prod[63:32];
            mlo  = prod[31:0];
            lat  = 4;
          end
          6'h10: if (MultEn) begin mwrite(rd, mhi); lat = 4; end
          6'h12: if (MultEn) begin mwrite(rd, mlo); lat = 4; end
          default: ;
        endcase
      end
      6'h08: begin mwrite(rt, s + imm); lat = 4; end
      6'h23: begin mwrite(rt, mdmem[maddr]); mrd = 1'b1; lat = 5; end
      6'h2b: begin mdmem[maddr] = t; mwd = t; mwr = 1'b1; lat = 4; end
      6'h04: if (s == t) npc = pc4 + (imm << 2);
      6'h05: if (s != t) npc = pc4 + (imm << 2);
      6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin mwrite(5'd31, pc4); npc = {pc4[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    mpc = npc;
  endtask

  // Feed one instruction with the given wait states and check everything it does.
  task automatic run_instr(input logic [31:0] ins, input int irw, input int dmw,
                           output int lat);
    int          mlat;
    bit          mrd, mwr;
    logic [6:0]  maddr;
    logic [31:0] mwd;
    int          mem_cyc = 0;
    int          bad_ctl = 0;
    bit          done    = 1'b0;
    model_exec(ins, mlat, mrd, mwr, maddr, mwd);
    lat    = 0;
    bus.IR = ins;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.IR_ready   = (lat > irw);
      bus.DMEM_ready = 1'b0;
      bus.ReadDataMem = 32'hDEAD_BEEF;
      if (!bus.CEN) begin
        mem_cyc++;
        check("mem_addr", 32'(bus.A), 32'(maddr));
        check("mem_oen_wen", {30'b0, bus.OEN, bus.WEN}, mwr ? 32'd2 : 32'd1);
        if (mwr) check("mem_wdata", bus.Data2Mem, mwd);
        if (mem_cyc > dmw) begin
          bus.DMEM_ready  = 1'b1;
          bus.ReadDataMem = dmem[bus.A];
          if (!bus.WEN) dmem[bus.A] = bus.Data2Mem;
        end
      end else if (!bus.OEN || !bus.WEN) begin
        bad_ctl++;
      end
      #1;
      if (bus.retire) done = 1'b1;
    end
    check("retire_seen", 32'(done), 32'd1);
    check("latency", lat, mlat + irw + ((mrd || mwr) ? dmw : 0));
    check("mem_cycles", mem_cyc, (mrd || mwr) ? dmw + 1 : 0);
    check("idle_strobes", bad_ctl, 0);
    @(posedge clk);
    #1;
    check("pc", bus.IR_addr, mpc);
    check_regs("regfile");
  endtask

  function automatic logic [31:0] rand_instr();
    int          rs  = $urandom_range(0, 7);
    int          rt  = $urandom_range(0, 7);
    int          rd  = $urandom_range(0, 7);
    int          sh  = $urandom_range(0, 31);
    logic [15:0] imm = 16'($urandom);
    logic [15:0] off = 16'($signed($urandom_range(0, 15)) - 8);
    case ($urandom_range(0, 18))
      0:  return rtype(rs, rt, rd, 0, 6'h20);
      1:  return rtype(rs, rt, rd, 0, 6'h22);
      2:  return rtype(rs, rt, rd, 0, 6'h24);
      3:  return rtype(rs, rt, rd, 0, 6'h25);
      4:  return rtype(rs, rt, rd, 0, 6'h2a);
      5:  return rtype(rs, rt, rd, sh, 6'h00);
      6:  return rtype(rs, rt, rd, sh, 6'h02);
      7:  return itype(6'h08, rs, rt, imm);
      8:  return itype(6'h23, rs, rt, imm);
      9:  return itype(6'h2b, rs, rt, imm);
      10: return itype(6'h04, rs, rt, off);
      11: return itype(6'h05, rs, rt, off);
      12: return jtype(6'h02, 26'($urandom));
      13: return jtype(6'h03, 26'($urandom));
      14: return rtype(rs, 0, 0, 0, 6'h08);
      15: return rtype(rs, rt, 0, 0, 6'h18);
      16: return rtype(0, 0, rd, 0, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12);
      17: return rtype(rs, rt, rd, 0, 6'h3f);
      default: return {6'h3f, 26'($urandom)};
    endcase
  endfunction

  initial begin
    int lat;
    bit seen;
    bit pulsed;

    vecs[0]  = '{itype(6'h08, 0, 1, 16'd5),      0, 0, 4, 32'h04,  1, 32'd5};
    vecs[1]  = '{itype(6'h08, 0, 2, 16'hfffd),   0, 0, 4, 32'h08,  2, 32'hffff_fffd};
    vecs[2]  = '{rtype(1, 2, 3, 0, 6'h20),       0, 0, 4, 32'h0c,  3, 32'd2};
    vecs[3]  = '{rtype(2, 1, 4, 0, 6'h2a),       1, 0, 5, 32'h10,  4, 32'd1};
    vecs[4]  = '{itype(6'h04, 1, 1, 16'hffff),   0, 0, 3, 32'h10,  1, 32'd5};
    vecs[5]  = '{itype(6'h05, 1, 1, 16'd4),      0, 0, 3, 32'h14,  1, 32'd5};
    vecs[6]  = '{itype(6'h2b, 0, 1, 16'd8),      0, 2, 6, 32'h18,  1, 32'd5};
    vecs[7]  = '{itype(6'h23, 0, 5, 16'd8),      0, 2, 7, 32'h1c,  5, 32'd5};
    vecs[8]  = '{jtype(6'h02, 26'h8),            0, 0, 3, 32'h20,  0, 32'd0};
    vecs[9]  = '{jtype(6'h03, 26'h40),           0, 0, 3, 32'h100, 31, 32'h24};
    vecs[10] = '{rtype(31, 0, 0, 0, 6'h08),      0, 0, 3, 32'h24,  31, 32'h24};
    vecs[11] = '{itype(6'h08, 0, 0, 16'd7),      0, 0, 4, 32'h28,  0, 32'd0};
    vecs[12] = '{rtype(0, 0, 6, 0, 6'h20),       0, 0, 4, 32'h2c,  6, 32'd0};
    vecs[13] = '{rtype(0, 1, 7, 4, 6'h00),       0, 0, 4, 32'h30,  7, 32'd80};
    vecs[14] = '{rtype(0, 2, 8, 28, 6'h02),      0, 0, 4, 32'h34,  8, 32'h0000_000f};
    vecs[15] = '{rtype(2, 1, 0, 0, 6'h18),       0, 0, MultEn ? 4 : 3, 32'h38, 0, 32'd0};
    vecs[16] = '{rtype(0, 0, 9, 0, 6'h10),       0, 0, MultEn ? 4 : 3, 32'h3c, 9,
                 MultEn ? 32'hffff_ffff : 32'd0};
    vecs[17] = '{rtype(0, 0, 10, 0, 6'h12),      0, 0, MultEn ? 4 : 3, 32'h40, 10,
                 MultEn ? 32'hffff_fff1 : 32'd0};
    vecs[18] = '{{6'h3f, 26'h123}, 0, 0, 3, 32'h44, 0, 32'd0};

    rst_n           = 1'b0;
    bus.IR          = '0;
    bus.IR_ready    = 1'b0;
    bus.ReadDataMem = '0;
    bus.DMEM_ready  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      dmem[i]  = $urandom;
      mdmem[i] = dmem[i];
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_cen_oen_wen", {29'b0, bus.CEN, bus.OEN, bus.WEN}, 32'd7);
    check("rst_A", 32'(bus.A), 32'd0);
    check("rst_data2mem", bus.Data2Mem, 32'd0);
    check("rst_retire", 32'(bus.retire), 32'd0);
    check("rst_pc", bus.IR_addr, ResetPc);
    check_regs("rst_regs");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NVec; k++) begin
      run_instr(vecs[k].ins, vecs[k].irw, vecs[k].dmw, lat);
      check($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
      check($sformatf("vec%0d_pc", k), bus.IR_addr, vecs[k].exp_pc);
      check($sformatf("vec%0d_r%0d", k, vecs[k].exp_r), dut.rf_q[vecs[k].exp_r], vecs[k].exp_v);
    end

    // Reset while a store is stalled in MEM must abort it cleanly.
    bus.IR         = itype(6'h2b, 0, 1, 16'd8);
    bus.DMEM_ready = 1'b0;
    seen           = 1'b0;
    pulsed         = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bus.IR_ready = 1'b1;
      #1;
      if (bus.retire) pulsed = 1'b1;
      if (!bus.CEN) seen = 1'b1;
    end
    check("abort_reached_mem", 32'(seen), 32'd1);
    check("abort_wen_in_mem", 32'(bus.WEN), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check("abort_no_retire", 32'(pulsed | bus.retire), 32'd0);
    check("abort_cen_wen", {30'b0, bus.CEN, bus.WEN}, 32'd3);
    check("abort_pc", bus.IR_addr, ResetPc);
    check_regs("abort_regs");
    bus.IR_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < NRand; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_mips.md
Name: multicycle_mips

Overview:
- Parametrised multi-cycle successor to the team's single-cycle MIPS core.
- Executes each instruction over a FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine.
- Stalls on ready handshakes from instruction and data memory, so it works with wait-state memories.
- Sits between the instruction ROM and the data SRAM, using the same active-low CEN/OEN/WEN memory convention as the current core.

Parameters:
- DMEM_AW, 7, data-memory word-address width; width of A.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREG_LOG2, 5, log2 of the register-file depth; the register file holds 2**NREG_LOG2 registers, and register fields use the low NREG_LOG2 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- IR_addr  output  32  instruction fetch address (the PC).
- IR  input  32  instruction word.
- IR_ready  input  1  high when IR is valid for IR_addr.
- ReadDataMem  input  32  load data from data memory.
- DMEM_ready  input  1  high when the data-memory access completes this cycle.
- CEN  output  1  data-memory chip enable, active low.
- OEN  output  1  data-memory read enable, active low.
- WEN  output  1  data-memory write enable, active low.
- A  output  DMEM_AW  data-memory word address.
- Data2Mem  output  32  store data.
- retire  output  1  one-cycle pulse when an instruction completes.

Behaviour:
- Reset values (next rising edge with rst_n=0):
  - PC=RESET_PC; all registers 0; state FETCH.
  - CEN=OEN=WEN=1; A=0; Data2Mem=0; retire=0.
- Reset mid-instruction aborts it: no register write, no memory write, no retire pulse.
- States:
  - FETCH: IR_addr=PC. While IR_ready=0, stay in FETCH. When IR_ready=1, latch IR into an internal IR register and go to DECODE.
  - DECODE: read rs and rt into operand registers, sign-extend imm16, go to EXECUTE.
  - EXECUTE:
    - Compute the ALU result into an ALUOut register.
    - beq/bne/j/jal/jr: update PC, pulse retire, go to FETCH.
    - lw/sw: go to MEM.
    - R-type ALU ops and addi: go to WRITEBACK.
  - MEM:
    - Drive CEN=0 and A=ALUOut[DMEM_AW+1:2].
    - lw: OEN=0, WEN=1. sw: WEN=0, OEN=1, Data2Mem=rt value.
    - Hold all of these until DMEM_ready=1.
    - On DMEM_ready: lw latches ReadDataMem and goes to WRITEBACK; sw sets PC=PC+4, pulses retire, goes to FETCH.
    - CEN/OEN/WEN are 1 in every other state.
  - WRITEBACK: write the destination register, set PC=PC+4, pulse retire, go to FETCH.
- Latency with zero wait states (FETCH to the retire cycle inclusive):
  - branch/jump: 3 cycles.
  - sw: 4 cycles.
  - R-type ALU ops and addi: 4 cycles.
  - lw: 5 cycles.
  - Each ready-low cycle adds 1.
- Instruction set:
  - R-type: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a (signed), sll 0x00, srl 0x02 (using shamt), jr 0x08.
  - I/J-type: addi 0x08, lw 0x23, sw 0x2b, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- Arithmetic is 32-bit wrap-around with no overflow trap.
- Branch target = PC+4 + (sext(imm)<<2).
- Jump target = {PC+4[31:28], target, 2'b00}.
- jal writes register 31 with PC+4 during EXECUTE.
- jr loads PC from rs.
- Register 0 always reads 0; writes to register 0 are discarded.
- Address bits [1:0] and bits above DMEM_AW+1 are ignored; no misalignment trap.
- Unknown opcode or funct: no-op; advance PC+4, pulse retire, 3 cycles.
- Back-to-back dependent instructions see correct values with no forwarding required, because the register file is written before the next DECODE.

Optional Feature:
- Macro MULT_EN.
- Defined:
  - Adds 32-bit HI/LO registers, reset to 0.
  - mult (funct 0x18) computes a signed 64-bit product in EXECUTE, writes {HI,LO} in WRITEBACK; writes no GPR.
  - mfhi (0x10) and mflo (0x12) copy HI or LO to rd in WRITEBACK.
  - Latency 4 cycles.
- Undefined: funct 0x18, 0x10 and 0x12 behave as unknown funct (3-cycle no-op); no HI/LO storage.

Test Plan:
- Reset then addi r1,r0,5 and addi r2,r0,-3, then add r3,r1,r2 -> r3=2; slt r4,r2,r1 -> r4=1; retire pulses at cycles 4, 8, 12 with IR_ready held high.
- sw r1,8(r0) with DMEM_ready low for 2 cycles -> CEN=0, WEN=0, A=2, Data2Mem=5 held for 3 cycles; then lw r5,8(r0) returning 5 -> r5=5 after a 7-cycle lw.
- beq r1,r1,-1 at PC=0x10 -> PC returns to 0x10. bne r1,r1,4 -> PC=0x14. jal 0x40 at PC=0x20 -> r31=0x24, PC=0x100. jr r31 -> PC=0x24.
- addi r0,r0,7, then add r6,r0,r0 -> r6=0. sll r7,r1,4 -> 80. srl r8,r2,28 -> 0xF.
- Assert rst_n=0 during the MEM state of a sw with DMEM_ready=0 -> next edge CEN=WEN=1, PC=RESET_PC, registers 0, no retire.
- MULT_EN defined: mult r2,r1 (-3*5), then mfhi r9 and mflo r10 -> r9=0xFFFF_FFFF, r10=0xFFFF_FFF1. MULT_EN undefined: same sequence leaves r9=r10=0, each instruction retiring in 3 cycles.
